// File: rtl/data_mem_responder.sv
// Data-memory responder: valid/ready request, programmable wait states, registered response.
// Optional word parity storage and checking enabled by defining MEM_PARITY_EN.
module data_mem_responder #(
  parameter int ADDR_W      = 8,
  parameter int DATA_W      = 32,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_rw,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;

  logic              lat_rw;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              err_q;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              accept;
  logic              do_access;
  logic              acc_rw;
  logic              acc_hit;
  logic              par_bad;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [IW-1:0]     acc_idx;

`ifdef MEM_PARITY_EN
  logic par [DEPTH];

  task automatic flip_parity(input logic [ADDR_W-1:0] a);
    par[a[IW-1:0]] = ~par[a[IW-1:0]];
  endtask
`endif

  // Next-state, handshake outputs and access strobe
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    accept    = 1'b0;
    do_access = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        accept    = req_valid;
        if (req_valid) begin
          if (WAIT_CYCLES == 0) begin
            do_access = 1'b1;
            state_d   = RESP;
          end else begin
            cnt_d   = 4'(WAIT_CYCLES - 1);
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          do_access = 1'b1;
          state_d   = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Zero-wait accesses use the live request; otherwise the latched copy
  always_comb begin
    acc_rw    = (state_q == IDLE) ? req_rw    : lat_rw;
    acc_addr  = (state_q == IDLE) ? req_addr  : lat_addr;
    acc_wdata = (state_q == IDLE) ? req_wdata : lat_wdata;
    acc_hit   = {1'b0, acc_addr} < (ADDR_W + 1)'(DEPTH);
    acc_idx   = acc_addr[IW-1:0];
`ifdef MEM_PARITY_EN
    par_bad   = par[acc_idx] != ~^mem[acc_idx];
`else
    par_bad   = 1'b0;
`endif
  end

  // State, request latch and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 4'd0;
      lat_rw    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        lat_rw    <= req_rw;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (do_access) begin
        rdata_q <= (!acc_rw && acc_hit) ? mem[acc_idx] : '0;
        err_q   <= !acc_hit || (!acc_rw && par_bad);
      end
    end
  end

  // Storage write; reset aborts a pending store
  always_ff @(posedge clk) begin
    if (!rst && do_access && acc_rw && acc_hit) begin
      mem[acc_idx] <= acc_wdata;
`ifdef MEM_PARITY_EN
      par[acc_idx] <= ~^acc_wdata;
`endif
    end
  end

  assign rsp_rdata = rdata_q;
  assign rsp_err   = err_q;

endmodule

// File: tb/tb_data_mem_responder.sv
// Directed bench for data_mem_responder (DEPTH=128, WAIT_CYCLES=2).
// Define MEM_PARITY_EN to exercise the parity path.
module tb_data_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_rw;
  logic [7:0]  req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int n_chk  = 0;
  int n_pass = 0;

  logic [31:0] rd;
  logic        er;

  data_mem_responder #(
    .ADDR_W(8),
    .DATA_W(32),
    .DEPTH(128),
    .WAIT_CYCLES(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", tag, got, exp);
  endtask

  task automatic do_req(input logic rw, input logic [7:0] a,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] r, output logic e);
    int lat;
    req_valid = 1'b1;
    req_rw    = rw;
    req_addr  = a;
    req_wdata = wd;
    chk("ready_idle", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_rw    = ~rw;
    req_addr  = 8'h3F;
    req_wdata = 32'h5555_5555;
    lat = 1;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, 3);
    r = rsp_rdata;
    e = rsp_err;
    for (int i = 0; i < hold; i++) begin
      req_valid = 1'b1;
      @(posedge clk); #1;
      chk("hold_valid", rsp_valid, 1);
      chk("hold_rdata", rsp_rdata, r);
      chk("ready_blocked", req_ready, 0);
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    chk("rsp_done", rsp_valid, 0);
    chk("ready_back", req_ready, 1);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = 1'b0;
    req_rw    = 1'b0;
    req_addr  = '0;
    req_wdata = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_ready", req_ready, 1);
    chk("rst_valid", rsp_valid, 0);
    chk("rst_rdata", rsp_rdata, 0);
    chk("rst_err", rsp_err, 0);

    do_req(1'b1, 8'h10, 32'hDEAD_BEEF, 0, rd, er);
    chk("wr10_rdata", rd, 0);
    chk("wr10_err", er, 0);
    do_req(1'b0, 8'h10, 32'h0, 0, rd, er);
    chk("rd10_rdata", rd, 32'hDEAD_BEEF);
    chk("rd10_err", er, 0);

    do_req(1'b1, 8'h05, 32'h0123_4567, 0, rd, er);
    do_req(1'b0, 8'h05, 32'h0, 4, rd, er);
    chk("rd05_rdata", rd, 32'h0123_4567);
    chk("rd05_err", er, 0);

    do_req(1'b1, 8'h00, 32'hCAFE_0000, 0, rd, er);
    do_req(1'b1, 8'h80, 32'h1, 0, rd, er);
    chk("wr80_err", er, 1);
    chk("wr80_rdata", rd, 0);
    do_req(1'b0, 8'h80, 32'h0, 0, rd, er);
    chk("rd80_err", er, 1);
    chk("rd80_rdata", rd, 0);
    do_req(1'b0, 8'h00, 32'h0, 0, rd, er);
    chk("rd00_rdata", rd, 32'hCAFE_0000);
    chk("rd00_err", er, 0);

    do_req(1'b1, 8'h20, 32'h1111_1111, 0, rd, er);
    req_valid = 1'b1;
    req_rw    = 1'b1;
    req_addr  = 8'h20;
    req_wdata = 32'h2222_2222;
    @(posedge clk); #1;
    req_valid = 1'b0;
    rst       = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_ready", req_ready, 1);
    chk("abort_valid", rsp_valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("abort_no_rsp", rsp_valid, 0);
    end
    do_req(1'b0, 8'h20, 32'h0, 0, rd, er);
    chk("rd20_rdata", rd, 32'h1111_1111);
    chk("rd20_err", er, 0);

    do_req(1'b1, 8'h30, 32'h0000_000F, 0, rd, er);
`ifdef MEM_PARITY_EN
    dut.flip_parity(8'h30);
    do_req(1'b0, 8'h30, 32'h0, 0, rd, er);
    chk("par_rdata", rd, 32'h0000_000F);
    chk("par_err", er, 1);
`else
    do_req(1'b0, 8'h30, 32'h0, 0, rd, er);
    chk("par_rdata", rd, 32'h0000_000F);
    chk("par_err", er, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
